// File: rtl/cpu_pkg.sv
// Shared cpu-side definitions: code-memory geometry and the program loader state encoding.
// Used by prog_loader and word_packer.
package cpu_pkg;

  localparam int ADDR_W  = 16;
  localparam int DATA_W  = 16;
  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_HI = 3'd1,
    ST_LEN_LO = 3'd2,
    ST_DAT_HI = 3'd3,
    ST_DAT_LO = 3'd4,
    ST_CHK    = 3'd5,
    ST_DONE   = 3'd6,
    ST_ERR    = 3'd7
  } loader_state_t;

  // States in which the loader holds rx_ready high.
  function automatic logic accepts_byte(input loader_state_t s);
    return (s == ST_LEN_HI) || (s == ST_LEN_LO) || (s == ST_DAT_HI) ||
           (s == ST_DAT_LO) || (s == ST_CHK);
  endfunction

endpackage

// File: rtl/word_packer.sv
// Packs a big-endian byte pair into a 16-bit code word and emits a
// one-cycle word_rdy pulse the cycle after the low byte arrives.
module word_packer
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              byte_stb,
  input  logic              sel_hi,
  input  logic [7:0]        byte_in,
  output logic [DATA_W-1:0] word,
  output logic              word_rdy
);

  logic [7:0]        hi_reg;
  logic [DATA_W-1:0] word_reg;
  logic              rdy_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_reg   <= 8'h00;
      word_reg <= '0;
      rdy_reg  <= 1'b0;
    end else begin
      rdy_reg <= byte_stb & ~sel_hi;
      if (byte_stb && sel_hi)
        hi_reg <= byte_in;
      if (byte_stb && !sel_hi)
        word_reg <= {hi_reg, byte_in};
    end
  end

  assign word     = word_reg;
  assign word_rdy = rdy_reg;

endmodule

// File: rtl/prog_loader.sv
// Boot-time program loader: length header + big-endian code words over a byte link,
// holds the cpu in reset until loaded. Define LOADER_CHECKSUM_EN for a trailing XOR byte.
module prog_loader
  import cpu_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR = 16'h0000,
  parameter int                MAX_WORDS = 1024
)
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              rx_valid,
  input  logic [7:0]        rx_byte,
  output logic              rx_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [15:0]       word_count
);

  localparam logic [16:0] MAX_LEN = 17'(MAX_WORDS);

`ifdef LOADER_CHECKSUM_EN
  localparam loader_state_t ST_FINAL = ST_CHK;
  logic [7:0] csum_reg;
`else
  localparam loader_state_t ST_FINAL = ST_DONE;
`endif

  loader_state_t     state_reg, state_next;
  logic              rx_ready_reg, busy_reg, done_reg, err_reg, cpu_reset_reg;
  logic [7:0]        len_hi_reg;
  logic [15:0]       len_reg;
  logic [15:0]       word_count_reg;
  logic [ADDR_W-1:0] wr_addr_reg;
  logic [15:0]       len_word;
  logic [15:0]       word_count_next;
  logic              xfer;
  logic              can_start;
  logic              data_stb;

  assign xfer            = rx_valid & rx_ready_reg;
  assign len_word        = {len_hi_reg, rx_byte};
  assign word_count_next = word_count_reg + 16'd1;
  assign can_start       = start && ((state_reg == ST_IDLE) || (state_reg == ST_DONE) ||
                                     (state_reg == ST_ERR));
  assign data_stb        = xfer && ((state_reg == ST_DAT_HI) || (state_reg == ST_DAT_LO));

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE, ST_DONE, ST_ERR: if (start) state_next = ST_LEN_HI;
      ST_LEN_HI: if (xfer) state_next = ST_LEN_LO;
      ST_LEN_LO: if (xfer) begin
        if ({1'b0, len_word} > MAX_LEN) state_next = ST_ERR;
        else if (len_word == 16'd0)     state_next = ST_FINAL;
        else                            state_next = ST_DAT_HI;
      end
      ST_DAT_HI: if (xfer) state_next = ST_DAT_LO;
      ST_DAT_LO: if (xfer) state_next = (word_count_next == len_reg) ? ST_FINAL : ST_DAT_HI;
`ifdef LOADER_CHECKSUM_EN
      ST_CHK: if (xfer) state_next = (rx_byte == csum_reg) ? ST_DONE : ST_ERR;
`endif
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      rx_ready_reg   <= 1'b0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      err_reg        <= 1'b0;
      cpu_reset_reg  <= 1'b1;
      len_hi_reg     <= 8'h00;
      len_reg        <= 16'h0000;
      word_count_reg <= 16'h0000;
      wr_addr_reg    <= BASE_ADDR;
`ifdef LOADER_CHECKSUM_EN
      csum_reg       <= 8'h00;
`endif
    end else begin
      state_reg    <= state_next;
      rx_ready_reg <= accepts_byte(state_next);

      if (can_start) begin
        done_reg       <= 1'b0;
        err_reg        <= 1'b0;
        busy_reg       <= 1'b1;
        cpu_reset_reg  <= 1'b1;
        word_count_reg <= 16'h0000;
`ifdef LOADER_CHECKSUM_EN
        csum_reg       <= 8'h00;
`endif
      end

      if (xfer && state_reg == ST_LEN_HI) len_hi_reg <= rx_byte;
      if (xfer && state_reg == ST_LEN_LO) len_reg    <= len_word;

      // Address and count advance on the same edge that raises wr_en.
      if (xfer && state_reg == ST_DAT_LO) begin
        wr_addr_reg    <= BASE_ADDR + word_count_reg;
        word_count_reg <= word_count_next;
      end

`ifdef LOADER_CHECKSUM_EN
      if (xfer && state_reg != ST_CHK) csum_reg <= csum_reg ^ rx_byte;
`endif

      if (state_next == ST_DONE && state_reg != ST_DONE) begin
        busy_reg      <= 1'b0;
        done_reg      <= 1'b1;
        cpu_reset_reg <= 1'b0;
      end
      if (state_next == ST_ERR && state_reg != ST_ERR) begin
        busy_reg <= 1'b0;
        err_reg  <= 1'b1;
      end
    end
  end

  word_packer u_word_packer (
    .clk      (clk),
    .reset    (reset),
    .byte_stb (data_stb),
    .sel_hi   (state_reg == ST_DAT_HI),
    .byte_in  (rx_byte),
    .word     (wr_data),
    .word_rdy (wr_en)
  );

  assign rx_ready   = rx_ready_reg;
  assign wr_addr    = wr_addr_reg;
  assign cpu_reset  = cpu_reset_reg;
  assign busy       = busy_reg;
  assign done       = done_reg;
  assign err        = err_reg;
  assign word_count = word_count_reg;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader; follows LOADER_CHECKSUM_EN to decide whether images carry a checksum byte.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic        rx_ready, wr_en, cpu_reset, busy, done, err;
  logic [15:0] wr_addr, wr_data, word_count;

  int tests = 0;
  int failed = 0;
  int falls = 0;
  int exp_falls = 0;
  logic prev_cpu_reset = 1'b1;
  logic [15:0] log_addr[$];
  logic [15:0] log_data[$];

  prog_loader dut (
    .clk(clk), .reset(reset), .start(start), .rx_valid(rx_valid), .rx_byte(rx_byte),
    .rx_ready(rx_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cpu_reset(cpu_reset), .busy(busy), .done(done), .err(err), .word_count(word_count)
  );

  always #5 clk = ~clk;

  // Write and cpu-release monitor, sampled on the inactive edge.
  always @(negedge clk) begin
    if (wr_en) begin
      log_addr.push_back(wr_addr);
      log_data.push_back(wr_data);
      $display("[TB] write addr=%h data=%h", wr_addr, wr_data);
    end
    if (prev_cpu_reset && !cpu_reset) falls++;
    prev_cpu_reset = cpu_reset;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    rx_valid = 1'b1;
    rx_byte  = b;
    while (!rx_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("rx_ready_timeout", {31'd0, rx_ready}, 32'd1);
    @(negedge clk);
    rx_valid = 1'b0;
    $display("[TB] byte %h sent", b);
  endtask

  // Sends an image; gaps inserts random idle cycles, start_mid pulses start after the header.
  task automatic send_image(input logic [7:0] data[$], input bit gaps, input bit start_mid);
    logic [7:0] x = 8'h00;
    foreach (data[i]) begin
      if (start_mid && i == 2) begin
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
      send_byte(data[i]);
      x = x ^ data[i];
    end
`ifdef LOADER_CHECKSUM_EN
    send_byte(x);
`endif
  endtask

  task automatic settle();
    repeat (3) @(negedge clk);
    #1;
  endtask

  task automatic expect_write(input string tag, input int idx, input logic [15:0] a,
                              input logic [15:0] d);
    check({tag, "_addr"}, {16'd0, (idx < log_addr.size()) ? log_addr[idx] : 16'hxxxx}, {16'd0, a});
    check({tag, "_data"}, {16'd0, (idx < log_data.size()) ? log_data[idx] : 16'hxxxx}, {16'd0, d});
  endtask

  initial begin
    logic [7:0] img2[$];
    logic [7:0] img_bad_len[$];
    logic [7:0] img4[$];
    logic [7:0] img_good[$];
    logic [7:0] img_zero[$];
    int base;

    img2        = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
    img_bad_len = '{8'h04, 8'h01};
    img4        = '{8'h00, 8'h01, 8'h55, 8'hAA};
    img_good    = '{8'h00, 8'h01, 8'h12, 8'h34};
    img_zero    = '{8'h00, 8'h00};

    // Test 1: reset state
    #1 reset = 1'b1;
    #12;
    check("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_rx_ready", {31'd0, rx_ready}, 32'd0);
    check("rst_wr_addr", {16'd0, wr_addr}, 32'h0000);
    check("rst_wr_en", {31'd0, wr_en}, 32'd0);
    check("rst_word_count", {16'd0, word_count}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    settle();
    check("idle_cpu_reset", {31'd0, cpu_reset}, 32'd1);

    // Test 2: two-word image
    base = log_addr.size();
    pulse_start();
    #1;
    check("t2_busy", {31'd0, busy}, 32'd1);
    check("t2_rx_ready", {31'd0, rx_ready}, 32'd1);
    send_image(img2, 1'b0, 1'b0);
    settle();
    exp_falls++;
    check("t2_nwrites", log_addr.size() - base, 32'd2);
    expect_write("t2_w0", base, 16'h0000, 16'h1234);
    expect_write("t2_w1", base + 1, 16'h0001, 16'hABCD);
    check("t2_done", {31'd0, done}, 32'd1);
    check("t2_cpu_reset", {31'd0, cpu_reset}, 32'd0);
    check("t2_busy_end", {31'd0, busy}, 32'd0);
    check("t2_word_count", {16'd0, word_count}, 32'd2);

    // Test 3: header length 1025 exceeds MAX_WORDS
    base = log_addr.size();
    pulse_start();
    send_byte(img_bad_len[0]);
    send_byte(img_bad_len[1]);
    #1;
    check("t3_err", {31'd0, err}, 32'd1);
    check("t3_rx_ready", {31'd0, rx_ready}, 32'd0);
    check("t3_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    check("t3_done", {31'd0, done}, 32'd0);
    settle();
    check("t3_nwrites", log_addr.size() - base, 32'd0);
    check("t3_busy", {31'd0, busy}, 32'd0);

    // Test 4: single word, bad checksum then a good image
    base = log_addr.size();
    pulse_start();
`ifdef LOADER_CHECKSUM_EN
    foreach (img4[i]) send_byte(img4[i]);
    send_byte(8'hFF);
    settle();
    check("t4_nwrites", log_addr.size() - base, 32'd1);
    expect_write("t4_w0", base, 16'h0000, 16'h55AA);
    check("t4_err", {31'd0, err}, 32'd1);
    check("t4_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    base = log_addr.size();
    pulse_start();
    send_image(img_good, 1'b0, 1'b0);
    settle();
    exp_falls++;
    expect_write("t4_good", base, 16'h0000, 16'h1234);
`else
    send_image(img4, 1'b0, 1'b0);
    settle();
    exp_falls++;
    check("t4_nwrites", log_addr.size() - base, 32'd1);
    expect_write("t4_w0", base, 16'h0000, 16'h55AA);
`endif
    check("t4_done", {31'd0, done}, 32'd1);
    check("t4_err_clear", {31'd0, err}, 32'd0);

    // Test 5: test 2 image with random rx_valid gaps and a start pulse mid-load
    base = log_addr.size();
    pulse_start();
    send_image(img2, 1'b1, 1'b1);
    settle();
    exp_falls++;
    check("t5_nwrites", log_addr.size() - base, 32'd2);
    expect_write("t5_w0", base, 16'h0000, 16'h1234);
    expect_write("t5_w1", base + 1, 16'h0001, 16'hABCD);
    check("t5_done", {31'd0, done}, 32'd1);
    check("t5_word_count", {16'd0, word_count}, 32'd2);

    // Zero-length image: no writes, straight to done
    base = log_addr.size();
    pulse_start();
    send_image(img_zero, 1'b0, 1'b0);
    settle();
    exp_falls++;
    check("len0_nwrites", log_addr.size() - base, 32'd0);
    check("len0_done", {31'd0, done}, 32'd1);
    check("len0_word_count", {16'd0, word_count}, 32'd0);

    // Test 6: reset after the first word of a 3-word load
    base = log_addr.size();
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h03);
    send_byte(8'h11);
    send_byte(8'h22);
    rx_valid = 1'b1;
    rx_byte  = 8'h33;
    reset    = 1'b1;
    #1;
    check("t6_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    check("t6_busy", {31'd0, busy}, 32'd0);
    check("t6_rx_ready", {31'd0, rx_ready}, 32'd0);
    check("t6_word_count", {16'd0, word_count}, 32'd0);
    check("t6_wr_addr", {16'd0, wr_addr}, 32'h0000);
    repeat (2) @(negedge clk);
    rx_valid = 1'b0;
    reset    = 1'b0;
    settle();
    check("t6_nwrites", log_addr.size() - base, 32'd1);
    expect_write("t6_w0", base, 16'h0000, 16'h1122);
    check("t6_idle_rx_ready", {31'd0, rx_ready}, 32'd0);
    base = log_addr.size();
    pulse_start();
    send_image('{8'h00, 8'h01, 8'hBE, 8'hEF}, 1'b0, 1'b0);
    settle();
    exp_falls++;
    expect_write("t6_fresh", base, 16'h0000, 16'hBEEF);
    check("t6_done", {31'd0, done}, 32'd1);
    check("t6_cpu_reset_low", {31'd0, cpu_reset}, 32'd0);

    check("cpu_release_count", falls, exp_falls);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
